// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among g_NUM_REQ producers.
// Each grant accepts up to g_BURST words and never writes while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int g_WIDTH   = 8,
  parameter int g_NUM_REQ = 4,
  parameter int g_BURST   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [g_NUM_REQ-1:0]           i_req_valid,
  input  logic [g_NUM_REQ*g_WIDTH-1:0]   i_req_data,
  output logic [g_NUM_REQ-1:0]           o_req_ready,
  input  logic                           i_fifo_full,
  output logic                           o_fifo_wr_en,
  output logic [g_WIDTH-1:0]             o_fifo_wr_data,
  output logic [$clog2(g_NUM_REQ)-1:0]   o_grant_src,
  output logic                           o_busy
);

  localparam int c_IDX_W  = $clog2(g_NUM_REQ);
  localparam int c_BEAT_W = $clog2(g_BURST + 1);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_GRANT = 1'b1;

  localparam logic [c_IDX_W-1:0]  c_LAST_RST  = c_IDX_W'(g_NUM_REQ - 1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(g_BURST - 1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_ONE  = c_BEAT_W'(1);

  logic [0:0]          r_state;
  logic [c_IDX_W-1:0]  r_grant;
  logic [c_IDX_W-1:0]  r_last;
  logic [c_BEAT_W-1:0] r_beats;

  logic                w_found;
  logic                w_hit;
  logic [c_IDX_W-1:0]  w_idx;
  logic [c_IDX_W-1:0]  w_pick;
  logic                w_busy;
  logic                w_valid_g;
  logic                w_xfer;
  logic [g_WIDTH-1:0]  w_lane;

  // Search r_last+1, r_last+2, ... with wrap; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_idx   = '0;
    w_pick  = '0;
    for (int k = 1; k <= g_NUM_REQ; k++) begin
      w_idx   = c_IDX_W'((int'(r_last) + k) % g_NUM_REQ);
      w_hit   = !w_found && i_req_valid[w_idx];
      w_pick  = w_hit ? w_idx : w_pick;
      w_found = w_found | w_hit;
    end
  end

  assign w_busy    = (r_state == c_GRANT);
  assign w_valid_g = i_req_valid[r_grant];
  assign w_xfer    = w_busy & w_valid_g & ~i_fifo_full;
  assign w_lane    = i_req_data[int'(r_grant)*g_WIDTH +: g_WIDTH];

  assign o_fifo_wr_en = w_xfer;
  assign o_grant_src  = r_grant;
  assign o_busy       = w_busy;

  // Handshake and write data follow the granted lane; full withholds ready.
  always_comb begin
    o_req_ready = '0;
    if (w_busy) begin
      o_req_ready[r_grant] = ~i_fifo_full;
      o_fifo_wr_data       = w_lane;
    end else begin
      o_fifo_wr_data       = '0;
    end
  end

  // Arbitration FSM: IDLE picks the next requester, GRANT counts beats until burst end or release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= c_IDLE;
      r_grant <= '0;
      r_last  <= c_LAST_RST;
      r_beats <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_beats <= '0;
            r_state <= c_GRANT;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_GRANT: begin
          if (w_xfer) begin
            r_beats <= r_beats + c_BEAT_ONE;
          end else begin
            r_beats <= r_beats;
          end
          // A full stall with valid held keeps the grant; valid low releases even when full.
          if (!w_valid_g || (w_xfer && (r_beats == c_BEAT_LAST))) begin
            r_state <= c_IDLE;
            r_last  <= r_grant;
          end else begin
            r_state <= c_GRANT;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: requester word queues drive the lanes,
// and a scoreboard of expected (source, word) pairs is consumed as writes appear.
module tb_fifo_wr_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic [N-1:0]   i_req_valid;
  logic [N*W-1:0] i_req_data;
  logic [N-1:0]   o_req_ready;
  logic           i_fifo_full;
  logic           o_fifo_wr_en;
  logic [W-1:0]   o_fifo_wr_data;
  logic [1:0]     o_grant_src;
  logic           o_busy;

  fifo_wr_arbiter #(.g_WIDTH(8), .g_NUM_REQ(4), .g_BURST(4)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .i_req_data     (i_req_data),
    .o_req_ready    (o_req_ready),
    .i_fifo_full    (i_fifo_full),
    .o_fifo_wr_en   (o_fifo_wr_en),
    .o_fifo_wr_data (o_fifo_wr_data),
    .o_grant_src    (o_grant_src),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] src_q[N][$];
  logic [9:0] exp_q[$];
  logic       full_v = 1'b0;

  task automatic drive();
    for (int n = 0; n < N; n++) begin
      i_req_valid[n]       = (src_q[n].size() > 0);
      i_req_data[n*W +: W] = (src_q[n].size() > 0) ? src_q[n][0] : 8'h00;
    end
    i_fifo_full = full_v;
  endtask

  task automatic push_exp(input int src, input logic [7:0] d);
    exp_q.push_back({2'(src), d});
  endtask

  // Observe one cycle at the falling edge, consume the scoreboard, then advance and drive.
  task automatic step(output logic busy_o, output logic wr_o, output logic rdy_o,
                      output logic [1:0] src_o);
    logic [N-1:0] hs;
    logic [9:0]   e;
    @(negedge i_clk);
    busy_o = o_busy;
    wr_o   = o_fifo_wr_en;
    rdy_o  = |o_req_ready;
    src_o  = o_grant_src;
    hs     = i_req_valid & o_req_ready;
    if (o_fifo_wr_en) begin
      n_tests++;
      if (i_fifo_full !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_while_full: full=%b wr_en=1 required wr_en=0", i_fifo_full);
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got src=%0d data=%h, required no write",
                 o_grant_src, o_fifo_wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({o_grant_src, o_fifo_wr_data} !== e) begin
          n_fail++;
          $display("FAIL write: got src=%0d data=%h, required src=%0d data=%h",
                   o_grant_src, o_fifo_wr_data, e[9:8], e[7:0]);
        end
      end
    end
    @(posedge i_clk);
    #1;
    for (int n = 0; n < N; n++) begin
      if (hs[n] && src_q[n].size() > 0) void'(src_q[n].pop_front());
    end
    drive();
  endtask

  task automatic apply_reset();
    for (int n = 0; n < N; n++) src_q[n].delete();
    exp_q.delete();
    full_v = 1'b0;
    i_rst  = 1'b1;
    drive();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    drive();
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d pending writes, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge i_clk);
      #1;
      i_req_valid = 4'($urandom_range(0, 15));
      i_req_data  = 32'($urandom);
      i_fifo_full = 1'($urandom_range(0, 1));
    end
    #3;
    i_rst = 1'b1;
    #1;
    n_tests++;
    if (o_req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rst_ready: got %b required 0000", o_req_ready);
    end
    n_tests++;
    if (o_fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_wr_en: got %b required 0", o_fifo_wr_en);
    end
    n_tests++;
    if (o_fifo_wr_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_wr_data: got %h required 00", o_fifo_wr_data);
    end
    n_tests++;
    if (o_grant_src !== 2'd0) begin
      n_fail++; $display("FAIL rst_grant_src: got %0d required 0", o_grant_src);
    end
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy: got %b required 0", o_busy);
    end
    apply_reset();
  endtask

  task automatic test_single_burst();
    logic b, w, r;
    logic [1:0] s;
    logic [9:0] busy_pat, wr_pat;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      src_q[2].push_back(8'(8'h10 + k));
      push_exp(2, 8'(8'h10 + k));
    end
    drive();
    for (int c = 0; c < 10; c++) begin
      step(b, w, r, s);
      busy_pat[c] = b;
      wr_pat[c]   = w;
    end
    n_tests++;
    if (busy_pat !== 10'b0111011110) begin
      n_fail++; $display("FAIL single_busy: got %b required 0111011110", busy_pat);
    end
    n_tests++;
    if (wr_pat !== 10'b0011011110) begin
      n_fail++; $display("FAIL single_wr: got %b required 0011011110", wr_pat);
    end
    check_drained("single");
  endtask

  task automatic test_round_robin();
    logic b, w, r;
    logic [1:0] s;
    apply_reset();
    for (int n = 0; n < N; n++) begin
      for (int k = 0; k < 8; k++) src_q[n].push_back(8'(n*16 + k));
    end
    for (int n = 0; n < N; n++) begin
      for (int k = 0; k < 4; k++) push_exp(n, 8'(n*16 + k));
    end
    for (int k = 4; k < 8; k++) push_exp(0, 8'(k));
    drive();
    for (int c = 0; c < 26; c++) step(b, w, r, s);
    check_drained("round_robin");
  endtask

  task automatic test_full_stall();
    logic b, w, r;
    logic [1:0] s;
    logic [11:0] busy_pat, wr_pat, rdy_pat;
    int src_bad;
    apply_reset();
    src_bad = 0;
    for (int k = 0; k < 4; k++) begin
      src_q[1].push_back(8'(8'h40 + k));
      push_exp(1, 8'(8'h40 + k));
    end
    drive();
    for (int c = 0; c < 12; c++) begin
      full_v = (c + 1 >= 3) && (c + 1 <= 7);
      step(b, w, r, s);
      busy_pat[c] = b;
      wr_pat[c]   = w;
      rdy_pat[c]  = r;
      if (c >= 1 && c <= 9 && s !== 2'd1) src_bad++;
    end
    n_tests++;
    if (wr_pat !== 12'b001100000110) begin
      n_fail++; $display("FAIL stall_wr: got %b required 001100000110", wr_pat);
    end
    n_tests++;
    if (rdy_pat !== 12'b001100000110) begin
      n_fail++; $display("FAIL stall_ready: got %b required 001100000110", rdy_pat);
    end
    n_tests++;
    if (busy_pat !== 12'b001111111110) begin
      n_fail++; $display("FAIL stall_busy: got %b required 001111111110", busy_pat);
    end
    n_tests++;
    if (src_bad !== 0) begin
      n_fail++; $display("FAIL stall_grant_held: got %0d cycles off requester 1, required 0", src_bad);
    end
    check_drained("stall");
  endtask

  task automatic test_early_release();
    logic b, w, r;
    logic [1:0] s;
    apply_reset();
    src_q[0].push_back(8'hA0);
    src_q[0].push_back(8'hA1);
    for (int k = 0; k < 6; k++) src_q[3].push_back(8'(8'hD0 + k));
    push_exp(0, 8'hA0);
    push_exp(0, 8'hA1);
    for (int k = 0; k < 4; k++) push_exp(3, 8'(8'hD0 + k));
    push_exp(0, 8'hA2);
    push_exp(0, 8'hA3);
    push_exp(3, 8'hD4);
    push_exp(3, 8'hD5);
    drive();
    for (int c = 0; c < 18; c++) begin
      if (c == 5) begin
        src_q[0].push_back(8'hA2);
        src_q[0].push_back(8'hA3);
      end
      step(b, w, r, s);
    end
    check_drained("early_release");
  endtask

  task automatic test_reset_mid_burst();
    logic b, w, r;
    logic [1:0] s;
    apply_reset();
    for (int k = 0; k < 6; k++) src_q[2].push_back(8'(8'h60 + k));
    push_exp(2, 8'h60);
    push_exp(2, 8'h61);
    drive();
    for (int c = 0; c < 3; c++) step(b, w, r, s);
    #2;
    n_tests++;
    if (o_fifo_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL mid_third_beat: got wr_en=%b required 1", o_fifo_wr_en);
    end
    i_rst = 1'b1;
    #1;
    n_tests++;
    if (o_fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_wr_en: got %b required 0", o_fifo_wr_en);
    end
    n_tests++;
    if (o_req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_rst_ready: got %b required 0000", o_req_ready);
    end
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_busy: got %b required 0", o_busy);
    end
    check_drained("mid_pre");
    repeat (2) @(posedge i_clk);
    #1;
    src_q[0].push_back(8'h01);
    src_q[0].push_back(8'h02);
    push_exp(0, 8'h01);
    push_exp(0, 8'h02);
    for (int k = 2; k < 6; k++) push_exp(2, 8'(8'h60 + k));
    i_rst = 1'b0;
    drive();
    for (int c = 0; c < 10; c++) step(b, w, r, s);
    check_drained("mid_post");
  endtask

  initial begin
    i_rst = 1'b1;
    drive();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the write port of a single register-based FIFO among `g_NUM_REQ` producers. Each producer offers words on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `g_BURST` words and drives the FIFO's write enable and write data. It never writes while the FIFO reports full, so the FIFO's full-write assertion can never fire.

## Interface

Parameters:
- `g_WIDTH`, 8 — data word width; must match the FIFO's `g_WIDTH`.
- `g_NUM_REQ`, 4 — number of requesters, ≥ 2.
- `g_BURST`, 4 — maximum words accepted per grant, ≥ 1.

Ports:
- `i_clk`  in  1 — clock; all state changes on rising edge.
- `i_rst`  in  1 — asynchronous, active-high reset.
- `i_req_valid`  in  `g_NUM_REQ` — bit n: requester n has a word on its data lane.
- `i_req_data`  in  `g_NUM_REQ*g_WIDTH` — flattened lanes; lane n is bits `[n*g_WIDTH +: g_WIDTH]`.
- `o_req_ready`  out  `g_NUM_REQ` — bit n: the word on lane n is accepted this cycle when valid.
- `i_fifo_full`  in  1 — FIFO full flag.
- `o_fifo_wr_en`  out  1 — FIFO write enable.
- `o_fifo_wr_data`  out  `g_WIDTH` — FIFO write data.
- `o_grant_src`  out  `$clog2(g_NUM_REQ)` — index of the currently or most recently granted requester.
- `o_busy`  out  1 — high while in GRANT.

## Operation

- State machine: IDLE and GRANT.
- Registers:
  - `r_state`
  - `r_grant` (index)
  - `r_last` (index of the last granted requester)
  - `r_beats` (width `$clog2(g_BURST+1)`)
- Reset values:
  - `r_state` = IDLE.
  - `r_grant` = 0.
  - `r_last` = `g_NUM_REQ-1`, so requester 0 has first priority.
  - `r_beats` = 0.
- Resulting output reset values:
  - `o_req_ready` = 0.
  - `o_fifo_wr_en` = 0.
  - `o_fifo_wr_data` = 0.
  - `o_grant_src` = 0.
  - `o_busy` = 0.
- IDLE:
  - If any `i_req_valid` bit is set, select the first set bit searching `r_last+1, r_last+2, …` with wrap at `g_NUM_REQ-1` → 0.
  - Load `r_grant` with that index, clear `r_beats`, and go to GRANT.
  - Otherwise remain in IDLE.
- GRANT, combinational outputs:
  - `o_req_ready[r_grant]` = !`i_fifo_full`; all other ready bits are 0.
  - `o_fifo_wr_en` = `i_req_valid[r_grant]` & !`i_fifo_full`; this cycle is a transfer.
  - `o_fifo_wr_data` = lane `r_grant` in GRANT, and 0 in IDLE.
- GRANT, on each transfer: `r_beats` increments.
- GRANT exits to IDLE, writing `r_last <= r_grant`, when either:
  - a transfer occurs with `r_beats == g_BURST-1` (burst complete), or
  - `i_req_valid[r_grant]` is low (requester released).
- `i_fifo_full` high in GRANT is a stall:
  - no transfer occurs and `r_beats` holds;
  - the grant is kept indefinitely (no timeout) while the requester stays valid.
- Valid low while full is still a release.
- Requesters other than `r_grant` are ignored in GRANT; their valid may stay high with no effect.
- `o_grant_src` = `r_grant`; it holds its value through IDLE.
- Asynchronous reset:
  - Forces all registers to their reset values immediately, independent of the clock, including mid-burst.
  - Words already written stay in the FIFO; the partial burst is simply cut off.

## Timing

- Arbitration latency: one cycle.
  - A valid first seen in IDLE at edge k produces GRANT and the first possible transfer in cycle k+1.
- Each grant therefore costs one IDLE bubble cycle.
  - Peak throughput: `g_BURST` words per `g_BURST+1` cycles.
- Within a grant: one word per cycle when valid is high and full is low.
- `o_fifo_wr_en`, `o_fifo_wr_data` and `o_req_ready` are combinational from `i_req_valid`, `i_req_data`, `i_fifo_full` and registered state.
  - The write is captured by the FIFO at the same edge on which the requester sees the handshake complete.
- `o_fifo_wr_en` must never be high in a cycle where `i_fifo_full` is high.
- The FIFO's full flag updates one cycle after a write.
  - The arbiter relies only on the current `i_fifo_full`, which is safe because the FIFO count includes all prior writes.
- A simultaneous FIFO read in the same cycle is irrelevant to the arbiter.

## Test plan

- **Reset:**
  - Stimulus: assert `i_rst` asynchronously with all inputs random.
  - Required: all outputs read 0 immediately (before the next edge), and `o_busy` = 0.
- **Single requester, burst split:**
  - Stimulus: `g_BURST`=4, requester 2 valid with words 0x10..0x15 and the FIFO empty.
  - Required:
    - writes 0x10–0x13 on four consecutive cycles, each with `o_grant_src`=2;
    - one IDLE cycle;
    - re-grant of requester 2, writing 0x14 and 0x15;
    - release.
- **Round robin:**
  - Stimulus: all four requesters continuously valid, with requester n sending 0xn0, 0xn1, ….
  - Required:
    - grant order 0, 1, 2, 3, 0;
    - 4 writes per grant;
    - each burst contains only that requester's words, in order.
- **Full stall:**
  - Stimulus: requester 1 granted; `i_fifo_full` goes high after 2 writes and is held for 5 cycles.
  - Required:
    - `o_fifo_wr_en`=0 and `o_req_ready`=0 for those 5 cycles;
    - grant held;
    - then exactly 2 more writes before release;
    - total 4.
- **Early release:**
  - Stimulus: requesters 0 and 3 valid; requester 0 drops valid after 2 transfers.
  - Required:
    - requester 0's grant ends with 2 words;
    - next IDLE grants requester 3;
    - after requester 3's burst, priority returns to requester 0.
- **Reset mid-burst:**
  - Stimulus: assert `i_rst` during requester 2's third beat.
  - Required:
    - immediate deassertion of write enable and ready;
    - after release, with requesters 0 and 2 both valid, requester 0 is granted first.
